uart_receiver: RTL

//  UART receive end paired with the team's uart sender; recovers 8N1 frames from serial line rx.
//  - Bit order MSB first, matching the transmitter: start(0), d[7]..d[0], stop(1).
//  - 16x oversampling, 2-FF input synchroniser, mid-bit sampling, start-glitch rejection.
//  - Framing check; presents each byte on a one-cycle rxValid strobe to downstream logic.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rx_os_tick.sv | 33 +++
 rtl/uart_receiver.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants, state encoding and baud-divider helper for the UART receive path.
// Optional even-parity support is selected with the UART_RX_PARITY_EN macro.
package uart_pkg;

  localparam int unsigned OS_RATE   = 16;
  localparam int unsigned MID_IDX   = OS_RATE / 2 - 1;
  localparam int unsigned LAST_IDX  = OS_RATE - 1;
  localparam int unsigned OS_CNT_W  = $clog2(OS_RATE);
  localparam int unsigned BIT_CNT_W = 4;
  localparam int unsigned DATA_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } rx_state_e;

  // Clocks per oversample tick, integer-truncated.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned os);
    return clk_freq / (baud * os);
  endfunction

endpackage

// File: rtl/uart_rx_os_tick.sv
// Free-running oversample tick generator: one-clock pulse every CLK_FREQ/(BAUD*OVERSAMPLE) clocks.
module uart_rx_os_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic os_tick
);

  localparam int unsigned DIV   = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      cnt     <= '0;
      os_tick <= 1'b0;
    end else if (cnt == CNT_W'(DIV - 1)) begin
      cnt     <= '0;
      os_tick <= 1'b1;
    end else begin
      cnt     <= cnt + CNT_W'(1);
      os_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, MSB first, 16x oversampled with mid-bit sampling and start-glitch rejection.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = OS_RATE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rxEn,
  input  logic              rx,
  output logic [DATA_W-1:0] out_data,
  output logic              rxValid,
  output logic              rxBusy,
  output logic              frameErr,
  output logic              parityErr
);

  logic                 clr;
  logic                 rx_meta, rx_s;
  logic                 os_tick;
  rx_state_e            state_q, state_d;
  logic [OS_CNT_W-1:0]  os_cnt_q, os_cnt_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]    shift_q, shift_d, data_d;
  logic                 valid_d, busy_d, ferr_d, perr_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
`endif

  assign clr = !rst_n || !rxEn;

  // Two-flop synchroniser for the asynchronous line.
  always_ff @(posedge clk) begin
    if (clr) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  uart_rx_os_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_os_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (rxEn),
    .os_tick(os_tick)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= ST_IDLE;
      os_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      out_data  <= '0;
      rxValid   <= 1'b0;
      rxBusy    <= 1'b0;
      frameErr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      parityErr <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      os_cnt_q  <= os_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      out_data  <= data_d;
      rxValid   <= valid_d;
      rxBusy    <= busy_d;
      frameErr  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
      parityErr <= perr_d;
`endif
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parityErr = 1'b0;
`endif

  // Frame sequencing; every state advances only on os_tick.
  always_comb begin
    state_d   = state_q;
    os_cnt_d  = os_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = out_data;
    busy_d    = rxBusy;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    perr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (os_tick && !rx_s) begin
          state_d  = ST_START;
          os_cnt_d = '0;
          busy_d   = 1'b1;
        end
      end
      ST_START: begin
        if (os_tick) begin
          if (os_cnt_q == OS_CNT_W'(MID_IDX)) begin
            os_cnt_d  = '0;
            bit_cnt_d = '0;
            if (!rx_s) begin
              state_d = ST_DATA;
            end else begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            os_cnt_d = os_cnt_q + OS_CNT_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (os_tick) begin
          if (os_cnt_q == OS_CNT_W'(LAST_IDX)) begin
            shift_d   = {shift_q[DATA_W-2:0], rx_s};
            os_cnt_d  = '0;
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if (bit_cnt_q == BIT_CNT_W'(DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end
          end else begin
            os_cnt_d = os_cnt_q + OS_CNT_W'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (os_tick) begin
          if (os_cnt_q == OS_CNT_W'(LAST_IDX)) begin
            par_d    = rx_s;
            os_cnt_d = '0;
            state_d  = ST_STOP;
          end else begin
            os_cnt_d = os_cnt_q + OS_CNT_W'(1);
          end
        end
      end
`endif
      ST_STOP: begin
        if (os_tick) begin
          if (os_cnt_q == OS_CNT_W'(LAST_IDX)) begin
            os_cnt_d = '0;
            state_d  = ST_IDLE;
            busy_d   = 1'b0;
            if (!rx_s) begin
              ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if ((^shift_q) ^ par_q) begin
              perr_d = 1'b1;
`endif
            end else begin
              valid_d = 1'b1;
              data_d  = shift_q;
            end
          end else begin
            os_cnt_d = os_cnt_q + OS_CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule
